// File: rtl/m_axi_txn_arbiter_if.sv
// Transaction-control bundle between requesters, the arbiter and the burst master.
// The master modport is the arbiter side; slave is the requester/master environment side.
interface m_axi_txn_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] req_error;
  logic               txn_start;
  logic               txn_done;
  logic               txn_error;
  logic               busy;
  logic [7:0]         err_cnt;
  logic [7:0]         timeout_cnt;

  modport master (
    input  req_valid, txn_done, txn_error,
    output grant, req_done, req_error, txn_start, busy, err_cnt, timeout_cnt
  );

  modport slave (
    output req_valid, txn_done, txn_error,
    input  grant, req_done, req_error, txn_start, busy, err_cnt, timeout_cnt
  );
endinterface

// File: rtl/m_axi_txn_arbiter.sv
// Round-robin arbiter sharing one burst master's start/done/error handshake among
// NUM_REQ requesters, with a completion watchdog and saturating error/timeout counters.
module m_axi_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     m_axi_aclk,
  input  logic                     m_axi_areset,
  m_axi_txn_arbiter_if.master      bus
);

  localparam int              IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic            TMO_EN_C   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0]     TMO_LAST_C = (TIMEOUT_CYCLES != 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  localparam logic [IDX_W-1:0] LAST_RST_C = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot_f(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  function automatic logic [7:0] sat_inc_f(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  state_e             state_r, state_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [NUM_REQ-1:0] done_r, done_nxt_s;
  logic [NUM_REQ-1:0] error_r, error_nxt_s;
  logic               start_r, start_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [15:0]        wdog_r, wdog_nxt_s;
  logic               err_lat_r, err_lat_nxt_s;
  logic               tmo_lat_r, tmo_lat_nxt_s;
  logic [IDX_W-1:0]   gidx_r, gidx_nxt_s;
  logic [IDX_W-1:0]   last_grant_r, last_nxt_s;
  logic [7:0]         err_cnt_r, err_cnt_nxt_s;
  logic [7:0]         tmo_cnt_r, tmo_cnt_nxt_s;
  logic               pick_found_s;
  logic [IDX_W-1:0]   pick_idx_s;

  // Round-robin search: first requester at or above last_grant+1, wrapping.
  always_comb begin
    int sum_v;
    int cand_v;
    sum_v        = 0;
    cand_v       = 0;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_v  = int'(last_grant_r) + 1 + i;
      cand_v = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
      if (!pick_found_s && bus.req_valid[cand_v[IDX_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_v[IDX_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state and next-output computation; every output is registered from these.
  always_comb begin
    state_nxt_s   = state_r;
    grant_nxt_s   = grant_r;
    done_nxt_s    = '0;
    error_nxt_s   = '0;
    start_nxt_s   = 1'b0;
    wdog_nxt_s    = wdog_r;
    err_lat_nxt_s = err_lat_r;
    tmo_lat_nxt_s = tmo_lat_r;
    gidx_nxt_s    = gidx_r;
    last_nxt_s    = last_grant_r;
    err_cnt_nxt_s = err_cnt_r;
    tmo_cnt_nxt_s = tmo_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = ST_START;
          grant_nxt_s = onehot_f(pick_idx_s);
          gidx_nxt_s  = pick_idx_s;
          start_nxt_s = 1'b1;
        end else begin
          grant_nxt_s = '0;
        end
      end
      ST_START: begin
        wdog_nxt_s    = 16'd0;
        err_lat_nxt_s = 1'b0;
        tmo_lat_nxt_s = 1'b0;
        state_nxt_s   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done in the same cycle as the watchdog expiry is a normal completion.
        if (bus.txn_done) begin
          err_lat_nxt_s = bus.txn_error;
          tmo_lat_nxt_s = 1'b0;
          done_nxt_s    = grant_r;
          error_nxt_s   = bus.txn_error ? grant_r : '0;
          state_nxt_s   = ST_RESP;
        end else if (TMO_EN_C && (wdog_r == TMO_LAST_C)) begin
          err_lat_nxt_s = 1'b1;
          tmo_lat_nxt_s = 1'b1;
          done_nxt_s    = grant_r;
          error_nxt_s   = grant_r;
          state_nxt_s   = ST_RESP;
        end else begin
          wdog_nxt_s = wdog_r + 16'd1;
        end
      end
      ST_RESP: begin
        if (err_lat_r) begin
          err_cnt_nxt_s = sat_inc_f(err_cnt_r);
        end else begin
          err_cnt_nxt_s = err_cnt_r;
        end
        if (tmo_lat_r) begin
          tmo_cnt_nxt_s = sat_inc_f(tmo_cnt_r);
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r;
        end
        last_nxt_s  = gidx_r;
        grant_nxt_s = '0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      done_r       <= '0;
      error_r      <= '0;
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      wdog_r       <= 16'd0;
      err_lat_r    <= 1'b0;
      tmo_lat_r    <= 1'b0;
      gidx_r       <= '0;
      last_grant_r <= LAST_RST_C;
      err_cnt_r    <= 8'd0;
      tmo_cnt_r    <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      done_r       <= done_nxt_s;
      error_r      <= error_nxt_s;
      start_r      <= start_nxt_s;
      busy_r       <= busy_nxt_s;
      wdog_r       <= wdog_nxt_s;
      err_lat_r    <= err_lat_nxt_s;
      tmo_lat_r    <= tmo_lat_nxt_s;
      gidx_r       <= gidx_nxt_s;
      last_grant_r <= last_nxt_s;
      err_cnt_r    <= err_cnt_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.req_done    = done_r;
  assign bus.req_error   = error_r;
  assign bus.txn_start   = start_r;
  assign bus.busy        = busy_r;
  assign bus.err_cnt     = err_cnt_r;
  assign bus.timeout_cnt = tmo_cnt_r;

endmodule

// File: doc/m_axi_txn_arbiter.md
# m_axi_txn_arbiter

Round-robin arbiter and sequencer that shares one AXI4 burst master's transaction-control interface (txn_start / txn_done / txn_error) among NUM_REQ requesters. It grants one requester at a time, pulses txn_start to the master, waits for completion under a watchdog, and returns per-requester done/error pulses. It also keeps saturating error and timeout counters. It sits between client engines and the burst master.

## Interface

- NUM_REQ, 4: number of requesters; legal range 2..16.
- TIMEOUT_CYCLES, 1024: WAIT-state cycles before a transaction is declared hung; 0 disables the watchdog; legal range 0..65535.

- m_axi_aclk  in  1  clock; all logic rising-edge.
- m_axi_areset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  level request per requester; held until its req_done.
- grant  out  NUM_REQ  one-hot owner of the master; zero when idle.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_error  out  NUM_REQ  asserted with req_done when completion carried an error or timed out.
- txn_start  out  1  one-cycle start pulse to the master.
- txn_done  in  1  one-cycle completion pulse from the master.
- txn_error  in  1  error flag, valid only with txn_done.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  8  saturating count of error completions, including timeouts.
- timeout_cnt  out  8  saturating count of watchdog timeouts.

## Operation

- FSM states: IDLE, START, WAIT, RESP. All outputs are registered.
- **IDLE**
  - If any req_valid bit is set, select the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping around.
  - Load grant with the selected one-hot value and go to START.
  - With no request, stay in IDLE.
- **START**: txn_start=1 for exactly this cycle. Clear the watchdog and go to WAIT.
- **WAIT**
  - txn_done=1: latch txn_error and go to RESP.
  - Otherwise, if TIMEOUT_CYCLES≠0 and watchdog==TIMEOUT_CYCLES-1: latch error=1, flag a timeout, and go to RESP.
  - Otherwise, increment the watchdog (16-bit).
  - If txn_done and the timeout arrive in the same cycle, txn_done wins: normal completion, not a timeout.
- **RESP**
  - req_done[g]=1 and req_error[g]=latched error, where g is the granted index.
  - Increment err_cnt if the latched error is set. Increment timeout_cnt if the timeout flag is set. Both counters saturate at 255.
  - Set last_grant=g and go to IDLE.
  - grant stays held through RESP and clears on entry to IDLE.
- txn_done and txn_error are ignored outside WAIT. A late done after a timeout is dropped; recovering the master is the system's responsibility.
- req_valid of the granted requester is ignored until IDLE. Deasserting it mid-transaction does not abort; req_done still pulses.
- Only one grant bit is ever set. req_done and req_error are never set for a non-granted index.

## Timing

- Reset: state=IDLE; grant, req_done, req_error, txn_start, busy, err_cnt and timeout_cnt all 0; watchdog 0; last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Reset mid-transaction: all outputs return to their reset values the next cycle, with no req_done pulse. The master shares the same reset.
- req_valid sampled in IDLE at cycle 0 → grant and txn_start at cycle 1 → WAIT from cycle 2.
- txn_done at WAIT cycle k → req_done at k+1 → IDLE at k+2, with grant=0 → next START at k+3 at the earliest.
- Minimum transaction occupancy is 4 cycles (START, one WAIT, RESP, IDLE).
- Timeout: with no done, RESP occurs in the cycle after the TIMEOUT_CYCLES-th WAIT cycle.
- A requester must drop req_valid by the cycle after req_done. Otherwise it is re-arbitrated, at lowest priority.

## Test plan

- Single request: after reset, req_valid=4'b0100 at cycle 0, txn_done at cycle 4 → grant=4'b0100 for cycles 1–5, txn_start only at cycle 1, req_done=4'b0100 at cycle 5, req_error=0, busy low at cycle 6.
- Fairness: req_valid=4'b1111 held, master answers done 2 cycles after each start → grant order 0,1,2,3,0,1; no requester granted twice before all others are served.
- Error path: done with txn_error=1 → req_error pulse coincident with req_done, err_cnt=1, timeout_cnt=0; a txn_done pulsed in IDLE is ignored.
- Watchdog: TIMEOUT_CYCLES=8, no done → RESP after 8 WAIT cycles, req_error=1, timeout_cnt=1, err_cnt=1. Repeat with done in WAIT cycle 8 → normal completion, timeout_cnt unchanged.
- Reset mid-WAIT with grant=4'b0010 → next cycle all outputs 0, no req_done. Then req_valid=4'b0011 → grant=4'b0001 first.
- Saturation: 300 consecutive error completions → err_cnt holds 255 and does not wrap to 0.
